pipe_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the DLX in-order pipeline. It replaces the ad-hoc per-stage forwarding and the kill flop with one scoreboard of in-flight destinations. From that scoreboard it produces operand-forward selects for ID and EX, the load-use stall, the branch kill, and a stall for a multi-cycle EX unit. It sits beside the ID stage and observes decode outputs; the datapath muxes consume its selects.

---
 rtl/dlx_pipe_pkg.sv | 30 +++
 rtl/pipe_hazard_unit_match.sv | 34 +++
 rtl/pipe_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pipe_pkg.sv
// Shared types and constants for the DLX pipeline control blocks.
// Scoreboard entries use a fixed-width destination field, so REG_AW must not exceed SB_DST_W.
package dlx_pipe_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int SB_DST_W   = 8;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                regwr;
        logic                is_load;
    } sb_entry_t;

    // Entry index to forward select; anything at or past entry 2 is WB data.
    function automatic logic [1:0] fwd_code(input int idx);
        if (idx == 0)
            return FWD_EX;
        else if (idx == 1)
            return FWD_MEM;
        else
            return FWD_WB;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand matcher: compares one source select against every scoreboard entry,
// returns the forward select of the youngest matching entry and a load-in-EX hit flag.
module pipe_hz_match
    import dlx_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3
) (
    input  logic [REG_AW-1:0]           sel,
    input  logic                        used,
    input  sb_entry_t [DEPTH-1:0]       entries,
    output logic [1:0]                  fwd,
    output logic                        load_hit
);

    logic [SB_DST_W-1:0] sel_ext;

    assign sel_ext = SB_DST_W'(sel);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd      = FWD_RF;
        load_hit = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && (sel != '0) && entries[i].valid && entries[i].regwr &&
                (entries[i].dst == sel_ext)) begin
                fwd = fwd_code(i);
                if (i == 0)
                    load_hit = entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the DLX in-order pipeline.
// Keeps a scoreboard of in-flight destinations (entry 0 = EX) and derives forwarding
// selects, load-use stall, multi-cycle EX hold and branch kill from it.
// State updates on the falling clock edge, like the interstage registers.
// Optional build macro PIPE_HAZARD_PERF_CNT_EN enables the saturating stall/flush counters.
//
// state | meaning
// IDLE  | no multi-cycle op holding EX (first EX cycle of an mc op also holds)
// BUSY  | mc op in EX; hold while counter > 1, op leaves EX on the edge at counter == 1
module pipe_hazard_unit
    import dlx_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3,
    parameter int MC_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_src_sel,
    input  logic [NSRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]        id_dst,
    input  logic                     id_regwr,
    input  logic                     id_is_load,
    input  logic                     id_is_mc,
    input  logic                     id_branch_taken,
    output logic [NSRC*2-1:0]        fwd_sel,
    output logic                     stall,
    output logic                     ex_hold,
    output logic                     kill_id,
    output logic                     flush_if,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    localparam int CNT_W = $clog2(MC_LAT + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} mc_state_t;

    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             id_entry;
    logic                  ex_is_mc;
    mc_state_t             mc_state;
    logic [CNT_W-1:0]      mc_cnt;
    logic                  flush_pending;
    logic [NSRC-1:0]       load_hit;
    logic                  mc_start;
    logic                  id_take;
    logic                  set_flush;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        pipe_hz_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_match (
            .sel      (id_src_sel[k*REG_AW +: REG_AW]),
            .used     (id_src_used[k]),
            .entries  (sb),
            .fwd      (fwd_sel[k*2 +: 2]),
            .load_hit (load_hit[k])
        );
    end

    // Hazard outputs and next-state qualifiers, all combinational from scoreboard and ID.
    always_comb begin
        mc_start       = (mc_state == ST_IDLE) && sb[0].valid && ex_is_mc;
        ex_hold        = mc_start || ((mc_state == ST_BUSY) && (mc_cnt != CNT_W'(1)));
        stall          = (|load_hit) || ex_hold;
        kill_id        = stall || flush_pending;
        id_take        = id_valid && !stall && !flush_pending;
        set_flush      = id_branch_taken && !stall && !flush_pending;
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.dst   = SB_DST_W'(id_dst);
        id_entry.regwr = id_regwr;
        id_entry.is_load = id_is_load;
    end

    assign flush_if = flush_pending;

    // Scoreboard shift; under ex_hold EX is frozen and a bubble enters MEM.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb       <= '0;
            ex_is_mc <= 1'b0;
        end else if (ex_hold) begin
            sb[1] <= '0;
            for (int i = 2; i < DEPTH; i++)
                sb[i] <= sb[i-1];
        end else begin
            sb[0]    <= id_take ? id_entry : '0;
            ex_is_mc <= id_take && id_is_mc;
            for (int i = 1; i < DEPTH; i++)
                sb[i] <= sb[i-1];
        end
    end

    // Multi-cycle EX sequencer.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_state <= ST_IDLE;
            mc_cnt   <= '0;
        end else begin
            case (mc_state)
                ST_IDLE: begin
                    if (mc_start) begin
                        mc_state <= ST_BUSY;
                        mc_cnt   <= CNT_W'(MC_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (mc_cnt == CNT_W'(1)) begin
                        mc_state <= ST_IDLE;
                        mc_cnt   <= '0;
                    end else begin
                        mc_cnt <= mc_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    mc_state <= ST_IDLE;
                    mc_cnt   <= '0;
                end
            endcase
        end
    end

    // One-cycle flush request after a taken branch leaves ID unstalled.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            flush_pending <= 1'b0;
        else
            flush_pending <= set_flush;
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (set_flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (default parameters). Inputs change just after the
// rising edge; outputs are checked before the falling (active) edge.
module tb_pipe_hazard_unit;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src_sel;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst;
    logic        id_regwr;
    logic        id_is_load;
    logic        id_is_mc;
    logic        id_branch_taken;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        ex_hold;
    logic        kill_id;
    logic        flush_if;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_dist [0:3];

    pipe_hazard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_src_sel      (id_src_sel),
        .id_src_used     (id_src_used),
        .id_dst          (id_dst),
        .id_regwr        (id_regwr),
        .id_is_load      (id_is_load),
        .id_is_mc        (id_is_mc),
        .id_branch_taken (id_branch_taken),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .ex_hold         (ex_hold),
        .kill_id         (kill_id),
        .flush_if        (flush_if),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic [4:0] dst, input logic wr,
                          input logic ld, input logic mc, input logic br);
        id_valid        = v;
        id_src_sel      = {s1, s0};
        id_src_used     = used;
        id_dst          = dst;
        id_regwr        = wr;
        id_is_load      = ld;
        id_is_mc        = mc;
        id_branch_taken = br;
    endtask

    task automatic issue(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic wr,
                         input logic ld, input logic mc, input logic br);
        @(posedge clk);
        #1;
        set_in(v, s0, s1, used, dst, wr, ld, mc, br);
        #1;
    endtask

    task automatic hold_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic alu(input logic [4:0] dst, input logic [4:0] s0, input logic [4:0] s1);
        issue(1'b1, s0, s1, 2'b11, dst, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] dst, input logic [4:0] s0);
        issue(1'b1, s0, 5'd0, 2'b01, dst, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mcop(input logic [4:0] dst, input logic [4:0] s0, input logic [4:0] s1);
        issue(1'b1, s0, s1, 2'b11, dst, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        nop();
        nop();
        nop();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_dist[0] = 2'd1;
        exp_dist[1] = 2'd2;
        exp_dist[2] = 2'd3;
        exp_dist[3] = 2'd0;

        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_fwd", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ex_hold", 32'(ex_hold), 32'd0);
        chk("rst_kill", 32'(kill_id), 32'd0);
        chk("rst_flush_if", 32'(flush_if), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // add r3 then sub r5,r3,r4 with 0..3 independent instructions between
        for (int d = 0; d < 4; d++) begin
            alu(5'd3, 5'd1, 5'd2);
            for (int j = 0; j < d; j++)
                alu(5'd10, 5'd11, 5'd12);
            alu(5'd5, 5'd3, 5'd4);
            chk($sformatf("fwd_dist%0d", d), 32'(fwd_sel), {30'd0, exp_dist[d]});
            chk($sformatf("stall_dist%0d", d), 32'(stall), 32'd0);
        end

        // operand 1 forwarding, then youngest writer wins on both operands
        alu(5'd6, 5'd1, 5'd2);
        alu(5'd7, 5'd1, 5'd6);
        chk("fwd_op1_ex", 32'(fwd_sel), 32'h4);
        alu(5'd6, 5'd1, 5'd2);
        alu(5'd9, 5'd6, 5'd6);
        chk("fwd_youngest", 32'(fwd_sel), 32'h5);

        // r0 is never forwarded
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd2, 5'd0, 5'd0);
        chk("fwd_r0", 32'(fwd_sel), 32'd0);
        chk("stall_r0", 32'(stall), 32'd0);

        // load-use
        clear();
        lw(5'd7, 5'd1);
        alu(5'd8, 5'd7, 5'd1);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_kill", 32'(kill_id), 32'd1);
        hold_cyc();
        chk("lu_stall_drop", 32'(stall), 32'd0);
        chk("lu_kill_drop", 32'(kill_id), 32'd0);
        chk("lu_fwd_mem", 32'(fwd_sel), 32'h2);
        chk("lu_stall_cnt", stall_cnt, 32'(PERF * 1));

        // multi-cycle op, MC_LAT = 4
        clear();
        alu(5'd14, 5'd1, 5'd2);
        mcop(5'd12, 5'd1, 5'd2);
        chk("mc_no_hold_before", 32'(ex_hold), 32'd0);
        alu(5'd13, 5'd12, 5'd14);
        chk("mc_hold_c1", 32'(ex_hold), 32'd1);
        chk("mc_stall_c1", 32'(stall), 32'd1);
        chk("mc_fwd_c1", 32'(fwd_sel), 32'h9);
        hold_cyc();
        chk("mc_hold_c2", 32'(ex_hold), 32'd1);
        chk("mc_fwd_c2", 32'(fwd_sel), 32'hD);
        hold_cyc();
        chk("mc_hold_c3", 32'(ex_hold), 32'd1);
        chk("mc_fwd_c3", 32'(fwd_sel), 32'h1);
        hold_cyc();
        chk("mc_hold_c4", 32'(ex_hold), 32'd0);
        chk("mc_stall_c4", 32'(stall), 32'd0);
        chk("mc_fwd_c4", 32'(fwd_sel), 32'h1);
        chk("mc_stall_cnt", stall_cnt, 32'(PERF * 4));
        alu(5'd15, 5'd13, 5'd12);
        chk("mc_after_hold", 32'(ex_hold), 32'd0);
        chk("mc_after_fwd", 32'(fwd_sel), 32'h9);

        // taken branch
        clear();
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br_flush_c0", 32'(flush_if), 32'd0);
        chk("br_kill_c0", 32'(kill_id), 32'd0);
        alu(5'd20, 5'd1, 5'd2);
        chk("br_flush_c1", 32'(flush_if), 32'd1);
        chk("br_kill_c1", 32'(kill_id), 32'd1);
        chk("br_flush_cnt", flush_cnt, 32'(PERF * 1));
        alu(5'd21, 5'd1, 5'd2);
        chk("br_flush_c2", 32'(flush_if), 32'd0);
        chk("br_kill_c2", 32'(kill_id), 32'd0);
        alu(5'd22, 5'd20, 5'd21);
        chk("br_killed_slot", 32'(fwd_sel), 32'h4);

        // taken branch during a load-use stall
        clear();
        lw(5'd7, 5'd1);
        issue(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("brs_stall", 32'(stall), 32'd1);
        chk("brs_flush_c0", 32'(flush_if), 32'd0);
        hold_cyc();
        chk("brs_stall_drop", 32'(stall), 32'd0);
        chk("brs_flush_c1", 32'(flush_if), 32'd0);
        nop();
        chk("brs_flush_c2", 32'(flush_if), 32'd1);
        chk("brs_flush_cnt", flush_cnt, 32'(PERF * 2));
        nop();
        chk("brs_flush_c3", 32'(flush_if), 32'd0);

        // reset pulse in the second BUSY cycle
        clear();
        mcop(5'd12, 5'd1, 5'd2);
        alu(5'd13, 5'd12, 5'd1);
        hold_cyc();
        hold_cyc();
        chk("rb_hold_busy2", 32'(ex_hold), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rb_fwd", 32'(fwd_sel), 32'd0);
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_ex_hold", 32'(ex_hold), 32'd0);
        chk("rb_kill", 32'(kill_id), 32'd0);
        chk("rb_flush_if", 32'(flush_if), 32'd0);
        chk("rb_stall_cnt", stall_cnt, 32'd0);
        chk("rb_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rb_idle_hold", 32'(ex_hold), 32'd0);
        alu(5'd5, 5'd3, 5'd4);
        chk("rb_first_capture", 32'(fwd_sel), 32'h1);
        chk("rb_idle_after", 32'(ex_hold), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
